// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the MIPS pipeline
// (register_file, decode stage, writeback scheduling).
package mips_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam logic [4:0]  ZERO_REG  = 5'd0;

  typedef logic [4:0]  reg_sel_t;
  typedef logic [31:0] word_t;

endpackage

// File: rtl/register_scoreboard.sv
// Busy scoreboard for pending register-file destinations: set on reservation,
// cleared when the register-file write retires, queried combinationally.
module register_scoreboard
  import mips_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     reserve_valid,
  input  reg_sel_t reserve_selector,
  input  logic     clear_valid,
  input  reg_sel_t clear_selector,
  input  reg_sel_t check_selector_1,
  input  reg_sel_t check_selector_2,
  output logic     busy_1,
  output logic     busy_2
);

  logic [REG_COUNT-1:1] busy_r;
  logic [REG_COUNT-1:0] busy_vec_s;

  // Per-register busy bits; a new reservation beats a same-edge retirement.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (reserve_valid && (reserve_selector == reg_sel_t'(i))) begin
          busy_r[i] <= 1'b1;
        end else if (clear_valid && (clear_selector == reg_sel_t'(i))) begin
          busy_r[i] <= 1'b0;
        end else begin
          busy_r[i] <= busy_r[i];
        end
      end
    end
  end

  // Register 0 is hardwired and never pending.
  assign busy_vec_s = {busy_r, 1'b0};
  assign busy_1     = busy_vec_s[check_selector_1];
  assign busy_2     = busy_vec_s[check_selector_2];

endmodule

// File: rtl/register_write_scheduler.sv
// Arbitrates the single register-file write port between ALU and load
// writeback, with ALU anti-starvation, and tracks pending destinations.
module register_write_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     reserve_valid,
  input  reg_sel_t reserve_selector,
  input  reg_sel_t check_selector_1,
  input  reg_sel_t check_selector_2,
  output logic     busy_1,
  output logic     busy_2,
  input  logic     alu_valid,
  output logic     alu_ready,
  input  reg_sel_t alu_selector,
  input  word_t    alu_value,
  input  logic     load_valid,
  output logic     load_ready,
  input  reg_sel_t load_selector,
  input  word_t    load_value,
  output logic     write_enable_3,
  output reg_sel_t selector_3,
  output word_t    value_3
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_r;
  logic                starved_s;
  logic                alu_xfer_s;
  logic                load_xfer_s;

  // Load normally wins; a starved ALU takes the port while both are valid.
  assign starved_s   = (starve_r == STARVE_W'(STARVE_LIMIT));
  assign alu_ready   = !reset && alu_valid && (!load_valid || starved_s);
  assign load_ready  = !reset && load_valid && !(alu_valid && starved_s);
  assign alu_xfer_s  = alu_valid && alu_ready;
  assign load_xfer_s = load_valid && load_ready;

  // Consecutive refused-ALU cycle counter, saturating at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_r <= '0;
    end else if (alu_valid && !alu_ready) begin
      starve_r <= starved_s ? starve_r : starve_r + STARVE_W'(1);
    end else begin
      starve_r <= '0;
    end
  end

  // Registered write stage driving register_file; selector 0 is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable_3 <= 1'b0;
      selector_3     <= ZERO_REG;
      value_3        <= 32'd0;
    end else if (alu_xfer_s) begin
      write_enable_3 <= (alu_selector != ZERO_REG);
      selector_3     <= alu_selector;
      value_3        <= alu_value;
    end else if (load_xfer_s) begin
      write_enable_3 <= (load_selector != ZERO_REG);
      selector_3     <= load_selector;
      value_3        <= load_value;
    end else begin
      write_enable_3 <= 1'b0;
      selector_3     <= selector_3;
      value_3        <= value_3;
    end
  end

  register_scoreboard u_scoreboard (
    .clock            (clock),
    .reset            (reset),
    .reserve_valid    (reserve_valid),
    .reserve_selector (reserve_selector),
    .clear_valid      (write_enable_3),
    .clear_selector   (selector_3),
    .check_selector_1 (check_selector_1),
    .check_selector_2 (check_selector_2),
    .busy_1           (busy_1),
    .busy_2           (busy_2)
  );

endmodule

// File: tb/tb_register_write_scheduler.sv
// Self-checking bench for register_write_scheduler: directed scenarios plus
// randomized traffic against a behavioural model of the port and scoreboard.
module tb_register_write_scheduler;
  import mips_pkg::*;

  localparam int LIMIT = 4;

  logic     clock = 1'b0;
  logic     reset;
  logic     reserve_valid;
  reg_sel_t reserve_selector;
  reg_sel_t check_selector_1;
  reg_sel_t check_selector_2;
  logic     busy_1;
  logic     busy_2;
  logic     alu_valid;
  logic     alu_ready;
  reg_sel_t alu_selector;
  word_t    alu_value;
  logic     load_valid;
  logic     load_ready;
  reg_sel_t load_selector;
  word_t    load_value;
  logic     write_enable_3;
  reg_sel_t selector_3;
  word_t    value_3;

  register_write_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .reserve_valid    (reserve_valid),
    .reserve_selector (reserve_selector),
    .check_selector_1 (check_selector_1),
    .check_selector_2 (check_selector_2),
    .busy_1           (busy_1),
    .busy_2           (busy_2),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_selector     (alu_selector),
    .alu_value        (alu_value),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_selector    (load_selector),
    .load_value       (load_value),
    .write_enable_3   (write_enable_3),
    .selector_3       (selector_3),
    .value_3          (value_3)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: pending-register set, ALU wait count, expected write port.
  bit          m_busy [32];
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_sel;
  logic [31:0] m_val;
  bit          last_alu_win;
  bit          last_alu_ready_dut;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0;
    m_we   = 1'b0;
    m_sel  = 5'd0;
    m_val  = 32'd0;
  endtask

  // One clock: check combinational outputs, advance the model, check write port.
  task automatic cycle();
    bit aw;
    bit lw;
    #1;
    aw = !reset && alu_valid && (!load_valid || (m_wait >= LIMIT));
    lw = !reset && load_valid && !aw;
    check("alu_ready", 32'(alu_ready), 32'(aw));
    check("load_ready", 32'(load_ready), 32'(lw));
    check("busy_1", 32'(busy_1), 32'(m_busy[check_selector_1]));
    check("busy_2", 32'(busy_2), 32'(m_busy[check_selector_2]));
    last_alu_win       = aw;
    last_alu_ready_dut = alu_ready;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (m_we) m_busy[m_sel] = 1'b0;
      if (reserve_valid && (reserve_selector != 5'd0)) m_busy[reserve_selector] = 1'b1;
      if (alu_valid && !aw) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
      else m_wait = 0;
      if (aw) begin
        m_we = (alu_selector != 5'd0); m_sel = alu_selector; m_val = alu_value;
      end else if (lw) begin
        m_we = (load_selector != 5'd0); m_sel = load_selector; m_val = load_value;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    check("write_enable_3", 32'(write_enable_3), 32'(m_we));
    check("selector_3", 32'(selector_3), 32'(m_sel));
    check("value_3", value_3, m_val);
    @(negedge clock);
  endtask

  initial begin
    int alu_grants;
    model_reset();
    reset = 1'b1;
    reserve_valid = 1'b0; reserve_selector = 5'd0;
    check_selector_1 = 5'd0; check_selector_2 = 5'd0;
    alu_valid = 1'b1; alu_selector = 5'd2; alu_value = 32'h0000_0011;
    load_valid = 1'b1; load_selector = 5'd5; load_value = 32'hDEAD_BEEF;
    cycle();
    cycle();
    check("reset_we", 32'(write_enable_3), 32'd0);
    check("reset_sel", 32'(selector_3), 32'd0);
    check("reset_val", value_3, 32'd0);

    // Load-only traffic: one write per cycle.
    reset = 1'b0; alu_valid = 1'b0;
    #1 check("load_only_ready", 32'(load_ready), 32'd1);
    repeat (3) cycle();
    check("load_only_we", 32'(write_enable_3), 32'd1);
    check("load_only_sel", 32'(selector_3), 32'd5);
    check("load_only_val", value_3, 32'hDEAD_BEEF);

    // Contention: load wins LIMIT times, then the ALU once.
    alu_valid = 1'b1; alu_selector = 5'd6; alu_value = 32'hA1A1_0006;
    load_selector = 5'd8; load_value = 32'hB2B2_0008;
    alu_grants = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("contention_alu_grant", 32'(last_alu_ready_dut), 32'((k % 5) == 4));
      if (last_alu_ready_dut) alu_grants++;
    end
    check("contention_alu_count", 32'(alu_grants), 32'd2);
    alu_valid = 1'b0; load_valid = 1'b0;
    repeat (2) cycle();

    // Scoreboard lifecycle on register 9.
    reserve_valid = 1'b1; reserve_selector = 5'd9;
    cycle();
    reserve_valid = 1'b0; check_selector_1 = 5'd9;
    #1 check("sb_busy9_set", 32'(busy_1), 32'd1);
    alu_valid = 1'b1; alu_selector = 5'd9; alu_value = 32'h1234_5678;
    cycle();
    alu_valid = 1'b0;
    check("sb_busy9_during_write", 32'(busy_1), 32'd1);
    cycle();
    check("sb_busy9_cleared", 32'(busy_1), 32'd0);

    // Same-edge reserve and retire of register 7: reservation wins.
    reserve_valid = 1'b1; reserve_selector = 5'd7;
    cycle();
    reserve_valid = 1'b0; alu_valid = 1'b1; alu_selector = 5'd7; alu_value = 32'h0000_0777;
    cycle();
    alu_valid = 1'b0; reserve_valid = 1'b1; reserve_selector = 5'd7;
    check("sim_we7", 32'(write_enable_3), 32'd1);
    cycle();
    reserve_valid = 1'b0; check_selector_2 = 5'd7;
    #1 check("sim_busy7", 32'(busy_2), 32'd1);
    cycle();
    check("sim_busy7_hold", 32'(busy_2), 32'd1);

    // Zero register: accepted but dropped, never busy.
    reserve_valid = 1'b1; reserve_selector = 5'd0;
    alu_valid = 1'b1; alu_selector = 5'd0; alu_value = 32'h5555_5555;
    check_selector_1 = 5'd0;
    #1 check("zero_alu_ready", 32'(alu_ready), 32'd1);
    cycle();
    reserve_valid = 1'b0; alu_valid = 1'b0;
    check("zero_we", 32'(write_enable_3), 32'd0);
    check("zero_busy", 32'(busy_1), 32'd0);

    // Reset mid-operation with registers 3 and 4 busy and a write in flight.
    reserve_valid = 1'b1; reserve_selector = 5'd3;
    cycle();
    reserve_selector = 5'd4;
    cycle();
    reserve_valid = 1'b0;
    load_valid = 1'b1; load_selector = 5'd3; load_value = 32'hCAFE_0003;
    cycle();
    reset = 1'b1; check_selector_1 = 5'd3; check_selector_2 = 5'd4;
    cycle();
    check("rst_busy3", 32'(busy_1), 32'd0);
    check("rst_busy4", 32'(busy_2), 32'd0);
    check("rst_we", 32'(write_enable_3), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_alu_ready", 32'(alu_ready), 32'd0);
    cycle();
    reset = 1'b0; load_valid = 1'b0;
    cycle();

    // Randomized traffic; requesters hold their request until accepted.
    for (int k = 0; k < 400; k++) begin
      if (!(alu_valid && !last_alu_win)) begin
        alu_valid    = ($urandom_range(0, 3) != 0);
        alu_selector = 5'($urandom);
        alu_value    = $urandom;
      end
      if (!(load_valid && !load_ready)) begin
        load_valid    = ($urandom_range(0, 2) == 0);
        load_selector = 5'($urandom);
        load_value    = $urandom;
      end
      reserve_valid    = ($urandom_range(0, 3) == 0);
      reserve_selector = 5'($urandom);
      check_selector_1 = 5'($urandom);
      check_selector_2 = 5'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_write_scheduler.md
# register_write_scheduler

Shares the single register-file write port (write_enable_3 / selector_3 / value_3) between two writeback requesters: the ALU result path and the load-return path. It also keeps a 32-entry busy scoreboard so the issue stage can stall on pending destinations. It sits between the execute/memory stages and register_file. Its write outputs drive register_file directly.

## Interface
- STARVE_LIMIT, 4: consecutive refused ALU cycles before the ALU gets priority; legal range 1–15.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- reserve_valid  in  1  issue stage marks a destination pending
- reserve_selector  in  5  destination register being reserved
- check_selector_1  in  5  source register to query
- check_selector_2  in  5  source register to query
- busy_1  out  1  combinational: check_selector_1 has a pending write
- busy_2  out  1  combinational: check_selector_2 has a pending write
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle
- alu_selector  in  5  ALU destination register
- alu_value  in  32  ALU result
- load_valid  in  1  load write request
- load_ready  out  1  load request accepted this cycle
- load_selector  in  5  load destination register
- load_value  in  32  load data
- write_enable_3  out  1  registered, to register_file
- selector_3  out  5  registered, to register_file
- value_3  out  32  registered, to register_file

## Operation
- **Handshake**
  - A transfer occurs when valid && ready.
  - A requester holds selector/value stable while valid && !ready.
  - ready is combinational from the valids and the starvation state.
  - At most one ready is high per cycle.
  - Both readies are 0 while reset is high.
- **Arbitration**
  - Default priority is load over ALU.
  - starve_count increments each cycle that alu_valid && !alu_ready, saturating at STARVE_LIMIT.
  - starve_count clears on an ALU transfer or when alu_valid is low.
  - When starve_count == STARVE_LIMIT and both requesters are valid, the ALU wins.
- **Write stage**
  - On a transfer, the next edge loads selector_3/value_3 from the winner.
  - write_enable_3 = 1 if the winner's selector != 0.
  - A selector-0 request is accepted normally but produces write_enable_3 = 0 (dropped).
  - With no transfer, write_enable_3 = 0; selector_3/value_3 hold their previous values.
- **Scoreboard**
  - busy[31:1] are state bits; busy[0] is constant 0.
  - Set at the edge when reserve_valid && reserve_selector != 0.
  - Cleared at the edge where write_enable_3 == 1 for selector_3, i.e. the edge at which register_file stores the value.
  - Same register reserved and cleared at the same edge: set wins, because a new producer is pending.
  - Reserving an already-busy register leaves it busy. There is no counting; the issue stage does not issue a second writer to a busy destination.
- **Reset**: busy all 0, starve_count = 0, write_enable_3 = 0, selector_3 = 0, value_3 = 0. A reset mid-transfer drops the in-flight write.

## Timing
- Accept at edge N (valid && ready in cycle N-1) -> write_enable_3 high during cycle N.
- register_file stores the value at edge N+1.
- busy drops at edge N+1, in the same cycle the new value is readable on the register-file read ports.
- Throughput is one write per cycle with no bubbles; register_file never back-pressures.
- A reservation made at edge R is visible on busy_x from cycle R onward.
- busy_x and the readies have zero latency (combinational).

## Structure
- **Package mips_pkg:**
  - REG_COUNT = 32
  - ZERO_REG = 5'd0
  - typedef reg_sel_t (logic [4:0])
  - typedef word_t (logic [31:0])
  - shared with register_file and the decode stage
- **Sub-module register_scoreboard** owns:
  - the busy vector and its set/clear rules
  - the two combinational query ports
- **Top level** owns:
  - arbitration and starve_count, width $clog2(STARVE_LIMIT+1)
  - the registered write stage

## Test plan
- **After reset, load-only traffic:** hold load_valid with selector 5, value 0xDEADBEEF.
  - load_ready = 1.
  - Next cycle write_enable_3 = 1, selector_3 = 5, value_3 = 0xDEADBEEF; one write per cycle.
- **Contention:** both valid every cycle with STARVE_LIMIT = 4.
  - Load wins 4 cycles, then ALU wins 1; the pattern repeats.
  - starve_count returns to 0 after each ALU grant.
- **Scoreboard lifecycle:** reserve register 9, then check_selector_1 = 9.
  - busy_1 = 1.
  - After the ALU write to 9, busy_1 = 0 in the same cycle register_file returns the new value.
- **Simultaneous set/clear on register 7:** reserve 7 at the same edge write_enable_3 retires 7.
  - busy for 7 stays 1.
- **Zero register:** reserve selector 0 and an ALU write to selector 0.
  - busy_1 for 0 stays 0.
  - alu_ready = 1; write_enable_3 stays 0.
- **Reset mid-operation:** assert reset with registers 3 and 4 busy and a write in flight.
  - Next cycle all busy = 0, write_enable_3 = 0, both readies = 0 while reset is held.
